// File: rtl/imem_loader_if.sv
// Host byte stream in, imem write port and load status out, bundled for imem_loader.
interface imem_loader_if #(parameter int ADDR_W = 6);
    logic              start;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    modport master (
        output start, in_byte, in_valid,
        input  in_ready, we, waddr, wdata, busy, done, error, word_count
    );

    modport slave (
        input  start, in_byte, in_valid,
        output in_ready, we, waddr, wdata, busy, done, error, word_count
    );
endinterface

// File: rtl/imem_loader.sv
// Packs big-endian program bytes into 32-bit words and writes them to sequential imem addresses until the stop opcode.
// Latency: 4th byte accepted in cycle N -> we in cycle N+1; next byte accepted no earlier than N+2.
// Backpressure: in_ready only in RECV; IMEM_LOADER_OPCHECK_EN adds opcode screening that aborts on an illegal word.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    imem_loader_if.slave bus
);
    localparam int MAX_WORDS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
    localparam logic [5:0] OP_STOP = 6'b111111;

    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

    state_t            state_q;
    logic [1:0]        idx_q;
    logic [23:0]       asm_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   wc_q;
    logic              in_ready_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic [31:0] word_d;
    logic        word_ok_d;

    assign word_d = {asm_q, bus.in_byte};

`ifdef IMEM_LOADER_OPCHECK_EN
    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
            6'b000010, 6'b010001, 6'b101000, 6'b111111: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction
    assign word_ok_d = op_legal(word_d[31:26]);
`else
    assign word_ok_d = 1'b1;
`endif

    // we_q doubles as the legality verdict of the word being written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            asm_q      <= 24'd0;
            addr_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
            wc_q       <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        state_q    <= RECV;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        wc_q       <= '0;
                        addr_q     <= '0;
                        idx_q      <= 2'd0;
                    end
                end
                RECV: begin
                    if (bus.in_valid && in_ready_q) begin
                        if (idx_q == 2'd3) begin
                            state_q    <= WRITE;
                            in_ready_q <= 1'b0;
                            wdata_q    <= word_d;
                            waddr_q    <= addr_q;
                            we_q       <= word_ok_d;
                        end else begin
                            asm_q <= {asm_q[15:0], bus.in_byte};
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    we_q <= 1'b0;
                    if (!we_q) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        wc_q <= wc_q + (ADDR_W+1)'(1);
                        if (wdata_q[31:26] == OP_STOP) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (waddr_q == LAST_ADDR) begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= RECV;
                            in_ready_q <= 1'b1;
                            addr_q     <= addr_q + ADDR_W'(1);
                            idx_q      <= 2'd0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.word_count = wc_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized program loads against a word-level reference model of the loader.
module tb_imem_loader;
    localparam int AW   = 2;
    localparam int MAXW = 1 << AW;
`ifdef IMEM_LOADER_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    typedef logic [7:0]     bq_t[$];
    typedef logic [AW+31:0] wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW)) bus();
    imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int total = 0;
    int passed = 0;
    int hs_total = 0;
    int exp_consumed;
    int exp_wc;
    logic exp_done, exp_err;
    wr_t exp_q[$];
    logic [31:0] wlog[$];
    bq_t prog;
    logic [5:0] legal_ops[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                                 6'b000010, 6'b010001, 6'b101000, 6'b111111};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] wlog_at(input int i);
        return (i < wlog.size()) ? wlog[i] : 32'hxxxxxxxx;
    endfunction

    task automatic add_word(input logic [31:0] w);
        prog.push_back(w[31:24]);
        prog.push_back(w[23:16]);
        prog.push_back(w[15:8]);
        prog.push_back(w[7:0]);
    endtask

    // Which words get written where, and how the load ends, from the program alone.
    task automatic model();
        logic [31:0] w;
        logic [AW-1:0] a;
        exp_q.delete();
        exp_wc = 0; exp_done = 1'b0; exp_err = 1'b0; exp_consumed = 0;
        for (int i = 0; i < prog.size() / 4; i++) begin
            w = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
            a = AW'(i);
            exp_consumed += 4;
            if (OPCHECK && !is_legal(w[31:26])) begin exp_err = 1'b1; break; end
            exp_q.push_back({a, w});
            exp_wc++;
            if (w[31:26] == 6'b111111) begin exp_done = 1'b1; break; end
            if (i == MAXW - 1) begin exp_err = 1'b1; break; end
        end
    endtask

    // One clock: count the handshake about to happen, then check outputs at the falling edge.
    task automatic tick();
        wr_t e;
        if (reset_n && bus.in_valid && bus.in_ready) hs_total++;
        @(negedge clk);
        if (bus.we) begin
            wlog.push_back(bus.wdata);
            check("we_in_ready_low", bus.in_ready, 0);
            check("we_busy", bus.busy, 1);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_we: got addr %0h data %0h expected no write", bus.waddr, bus.wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr_data", {bus.waddr, bus.wdata}, e);
            end
        end
        if (bus.done || bus.error) check("done_error_excl", bus.done & bus.error, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit ok;
        repeat ($urandom_range(0, maxgap)) begin bus.in_valid = 1'b0; tick(); end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin ok = bus.in_ready; tick(); end
        if (!ok) begin
            total++;
            $display("FAIL byte_accept_timeout: got in_ready=0 for 40 cycles expected acceptance");
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_clears", {bus.busy, bus.done, bus.error, bus.word_count},
              {1'b1, 1'b0, 1'b0, {(AW+1){1'b0}}});
    endtask

    task automatic run_load(input int maxgap);
        int base;
        model();
        wlog.delete();
        base = hs_total;
        do_start();
        for (int i = 0; i < exp_consumed; i++) send_byte(prog[i], maxgap);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hA5;
        repeat (4) tick();
        bus.in_valid = 1'b0;
        tick();
        check("bytes_consumed", hs_total - base, exp_consumed);
        check("done", bus.done, exp_done);
        check("error", bus.error, exp_err);
        check("word_count", bus.word_count, exp_wc);
        check("busy_end", bus.busy, 0);
        check("missing_writes", exp_q.size(), 0);
    endtask

    task automatic basic_prog();
        prog.delete();
        add_word(32'h20080005);
        add_word(32'hFC000000);
    endtask

    initial begin
        logic [31:0] w;
        logic [5:0]  op;
        int sp;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_byte = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.in_ready, bus.we, bus.waddr, bus.wdata, bus.busy,
              bus.done, bus.error, bus.word_count}, 0);
        reset_n = 1'b1;
        tick();
        check("idle_outputs", {bus.in_ready, bus.we, bus.busy, bus.done, bus.error}, 0);

        basic_prog();
        run_load(0);
        check("basic_nwrites", wlog.size(), 2);
        check("basic_w0", wlog_at(0), 32'h20080005);
        check("basic_w1", wlog_at(1), 32'hFC000000);
        check("basic_wc", bus.word_count, 2);

        #2 reset_n = 1'b0;
        #1 check("midcycle_reset", {bus.in_ready, bus.we, bus.waddr, bus.wdata, bus.busy,
                 bus.done, bus.error, bus.word_count}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        basic_prog();
        run_load(3);
        check("gap_w0", wlog_at(0), 32'h20080005);
        check("gap_w1", wlog_at(1), 32'hFC000000);

        prog.delete();
        repeat (4) add_word(32'h00000020);
        run_load(1);
        check("ovf_nwrites", wlog.size(), 4);
        check("ovf_error", {bus.error, bus.done}, 2'b10);
        check("ovf_wc", bus.word_count, 4);

        basic_prog();
        run_load(2);
        check("reload_w0", wlog_at(0), 32'h20080005);

        exp_q.delete();
        do_start();
        send_byte(8'h8C, 0);
        send_byte(8'h09, 0);
        bus.in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        check("midword_reset", {bus.busy, bus.in_ready, bus.word_count}, 0);
        reset_n = 1'b1;
        tick();
        prog.delete();
        add_word(32'h8C090000);
        add_word(32'hFC000000);
        run_load(1);
        check("after_reset_nwrites", wlog.size(), 2);
        check("after_reset_w0", wlog_at(0), 32'h8C090000);

        prog.delete();
        add_word(32'h7C000000);
        add_word(32'hFC000000);
        run_load(0);
`ifdef IMEM_LOADER_OPCHECK_EN
        check("opchk_nwrites", wlog.size(), 0);
        check("opchk_state", {bus.error, bus.word_count}, {1'b1, {(AW+1){1'b0}}});
`else
        check("noopchk_nwrites", wlog.size(), 2);
        check("noopchk_w0", wlog_at(0), 32'h7C000000);
`endif

        for (int n = 0; n < 25; n++) begin
            prog.delete();
            sp = $urandom_range(0, MAXW);
            for (int j = 0; j <= MAXW; j++) begin
                if (j == sp) op = 6'b111111;
                else if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 62));
                else op = legal_ops[$urandom_range(0, 7)];
                w = {op, 26'($urandom)};
                add_word(w);
            end
            run_load($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
